// File: rtl/pimac_dot_seq.sv
// Dot-product sequencer: streams VEC_LEN (a,b,c) beats into the PiMAC and sums the results.
// Build option PIMAC_DOT_SAT_EN: saturate the accumulator on overflow instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | accepting operand beats
// DRAIN  | waiting for in-flight MAC results
// OUTPUT | presenting the sum until out_ready
module pimac_dot_seq #(
   parameter int DW      = 4,
   parameter int RW      = 8,
   parameter int VEC_LEN = 8,
   parameter int MAC_LAT = 1,
   parameter int ACC_W   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   input  logic [DW-1:0]    in_c,
   output logic [DW-1:0]    mac_a,
   output logic [DW-1:0]    mac_b,
   output logic [DW-1:0]    mac_c,
   input  logic [RW-1:0]    mac_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             ovf
);

   localparam int CW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int AW1 = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUTPUT} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      beat_cnt;
   logic [MAC_LAT-1:0] pipe;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W:0]     sum;
   logic               beat;
   logic               last_beat;
   logic               drain_done;

   assign busy      = (state != IDLE);
   assign in_ready  = (state == STREAM);
   assign out_valid = (state == OUTPUT);
   assign out_data  = acc;

   assign beat      = in_ready && in_valid;
   assign last_beat = beat && (beat_cnt == CW'(VEC_LEN - 1));
   // pipe[0] is the slot retiring this cycle; drain ends once nothing else remains behind it
   assign drain_done = ((pipe >> 1) == '0);
   assign sum        = {1'b0, acc} + AW1'(mac_result);

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)      state_nxt = STREAM;
            STREAM:  if (last_beat)  state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = OUTPUT;
            OUTPUT:  if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         pipe     <= '0;
         acc      <= '0;
         ovf      <= 1'b0;
         mac_a    <= '0;
         mac_b    <= '0;
         mac_c    <= '0;
      end else begin
         state <= state_nxt;
         if (abort) begin
            beat_cnt <= '0;
            pipe     <= '0;
            acc      <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            mac_c    <= '0;
         end else begin
            pipe  <= (pipe >> 1) | (MAC_LAT'(beat) << (MAC_LAT - 1));
            mac_a <= beat ? in_a : '0;
            mac_b <= beat ? in_b : '0;
            mac_c <= beat ? in_c : '0;
            if ((state == IDLE) && start) begin
               beat_cnt <= '0;
               acc      <= '0;
               ovf      <= 1'b0;
            end else begin
               if (beat && !last_beat)
                  beat_cnt <= beat_cnt + 1'b1;
               if (pipe[0]) begin
                  if (sum[ACC_W]) begin
                     ovf <= 1'b1;
`ifdef PIMAC_DOT_SAT_EN
                     acc <= '1;
`else
                     acc <= sum[ACC_W-1:0];
`endif
                  end else begin
                     acc <= sum[ACC_W-1:0];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pimac_dot_seq.sv
// Directed bench for pimac_dot_seq: a 10-bit accumulator instance and an 8-bit one for overflow,
// each fed by a combinational a*b+c MAC model (MAC_LAT=1).
`timescale 1ns/1ps
module tb_pimac_dot_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] in_a = '0, in_b = '0, in_c = '0;

   logic       busy, in_ready, out_valid, ovf;
   logic [3:0] mac_a, mac_b, mac_c;
   logic [7:0] mac_result;
   logic [9:0] out_data;

   logic       busy8, in_ready8, out_valid8, ovf8;
   logic [3:0] mac_a8, mac_b8, mac_c8;
   logic [7:0] mac_result8;
   logic [7:0] out_data8;

   int checks = 0;
   int failures = 0;

   localparam logic [7:0] EXP8 =
`ifdef PIMAC_DOT_SAT_EN
      8'd255;
`else
      8'd192;
`endif

   always #5 clk = ~clk;

   assign mac_result  = {4'b0, mac_a}  * {4'b0, mac_b}  + {4'b0, mac_c};
   assign mac_result8 = {4'b0, mac_a8} * {4'b0, mac_b8} + {4'b0, mac_c8};

   pimac_dot_seq #(.DW(4), .RW(8), .VEC_LEN(4), .MAC_LAT(1), .ACC_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_result(mac_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf));

   pimac_dot_seq #(.DW(4), .RW(8), .VEC_LEN(4), .MAC_LAT(1), .ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy8),
      .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .mac_a(mac_a8), .mac_b(mac_b8), .mac_c(mac_c8), .mac_result(mac_result8),
      .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .ovf(ovf8));

   // All tasks enter and leave on a falling edge; the DUT samples inputs on the rising edge.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_a = a; in_b = b; in_c = c;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL beat_accept: in_ready=%b required=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_a = '0; in_b = '0; in_c = '0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL out_valid_timeout: out_valid=%b required=1", out_valid);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, in_ready, out_valid, ovf} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: busy/in_ready/out_valid/ovf=%b required=0000",
                  {busy, in_ready, out_valid, ovf});
      end
      checks++;
      if ({out_data, mac_a, mac_b, mac_c} !== 22'd0) begin
         failures++;
         $display("FAIL reset_data: out_data=%0d mac_a=%0d required 0", out_data, mac_a);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: busy=%b required=0", busy);
      end
   endtask

   task automatic test_reset_mid_stream();
      pulse_start();
      send_beat(4'd2, 4'd3, 4'd1, 0);
      send_beat(4'd2, 4'd3, 4'd1, 0);
      checks++;
      if (out_data !== 10'd7 || mac_a !== 4'd2) begin
         failures++;
         $display("FAIL mid_stream_partial: out_data=%0d mac_a=%0d required 7/2", out_data, mac_a);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, in_ready, out_valid, ovf} !== 4'b0000 || {out_data, mac_a, mac_b, mac_c} !== 22'd0) begin
         failures++;
         $display("FAIL async_reset: flags=%b out_data=%0d mac_a=%0d required all 0",
                  {busy, in_ready, out_valid, ovf}, out_data, mac_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      repeat (4) send_beat(4'd1, 4'd2, 4'd3, 0);
      wait_out();
      checks++;
      if (out_data !== 10'd20) begin
         failures++;
         $display("FAIL after_reset_sum: out_data=%0d required=20", out_data);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      pulse_start();
      send_beat(4'd3, 4'd5, 4'd1, 0);
      send_beat(4'd15, 4'd15, 4'd15, 0);
      send_beat(4'd0, 4'd7, 4'd2, 0);
      send_beat(4'd2, 4'd2, 4'd0, 0);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: out_valid=%b busy=%b in_ready=%b required 0/1/0",
                  out_valid, busy, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_latency: out_valid=%b required=1", out_valid);
      end
      checks++;
      if (out_data !== 10'd262 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL b2b_sum: out_data=%0d ovf=%b required 262/0", out_data, ovf);
      end
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL start_not_queued: busy=%b out_valid=%b required 0/0", busy, out_valid);
      end
   endtask

   task automatic test_gaps();
      pulse_start();
      send_beat(4'd3, 4'd5, 4'd1, 1);
      send_beat(4'd15, 4'd15, 4'd15, 3);
      send_beat(4'd0, 4'd7, 4'd2, 2);
      send_beat(4'd2, 4'd2, 4'd0, 1);
      in_valid = 1'b1;
      in_a = 4'd9; in_b = 4'd9; in_c = 4'd9;
      wait_out();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 10'd262 || in_ready !== 1'b0 || mac_a !== 4'd0) begin
            failures++;
            $display("FAIL gaps_hold[%0d]: out_valid=%b out_data=%0d in_ready=%b mac_a=%0d required 1/262/0/0",
                     i, out_valid, out_data, in_ready, mac_a);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_a = '0; in_b = '0; in_c = '0;
      consume();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL gaps_release: busy=%b required=0", busy);
      end
   endtask

   task automatic test_overflow();
      checks++;
      if (ovf8 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: ovf8=%b required=1", ovf8);
      end
      pulse_start();
      checks++;
      if (ovf8 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear_on_start: ovf8=%b required=0", ovf8);
      end
      repeat (4) send_beat(4'd15, 4'd15, 4'd15, 0);
      wait_out();
      checks++;
      if (out_data8 !== EXP8 || ovf8 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_acc8: out_data=%0d ovf=%b required %0d/1", out_data8, ovf8, EXP8);
      end
      checks++;
      if ({busy8, in_ready8, out_valid8} !== 3'b101) begin
         failures++;
         $display("FAIL ovf_flags8: busy/in_ready/out_valid=%b required=101",
                  {busy8, in_ready8, out_valid8});
      end
      checks++;
      if (out_data !== 10'd960 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_acc10: out_data=%0d ovf=%b required 960/0", out_data, ovf);
      end
      consume();
   endtask

   task automatic test_abort();
      pulse_start();
      send_beat(4'd3, 4'd5, 4'd1, 0);
      send_beat(4'd15, 4'd15, 4'd15, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 10'd0 || mac_a !== 4'd0) begin
         failures++;
         $display("FAIL abort_flush: busy=%b in_ready=%b out_data=%0d mac_a=%0d required 0/0/0/0",
                  busy, in_ready, out_data, mac_a);
      end
      @(negedge clk);
      checks++;
      if (out_data !== 10'd0) begin
         failures++;
         $display("FAIL abort_pipe_flush: out_data=%0d required=0", out_data);
      end
      pulse_start();
      send_beat(4'd1, 4'd1, 4'd0, 0);
      send_beat(4'd1, 4'd1, 4'd0, 0);
      pulse_start();
      send_beat(4'd1, 4'd1, 4'd0, 0);
      send_beat(4'd1, 4'd1, 4'd0, 0);
      wait_out();
      checks++;
      if (out_data !== 10'd4) begin
         failures++;
         $display("FAIL abort_new_vector: out_data=%0d required=4", out_data);
      end
      abort = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 10'd0) begin
         failures++;
         $display("FAIL abort_in_output: busy=%b out_valid=%b out_data=%0d required 0/0/0",
                  busy, out_valid, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_stream();
      test_back_to_back();
      test_gaps();
      test_overflow();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
